// File: rtl/kamacore_pkg.sv
// kamacore_pkg: shared CPU width and data-memory enums
package kamacore_pkg;
  localparam int CPU_WIDTH = 32;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_size_e;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_e;
endpackage

// File: rtl/kamacore_dmem_lane_align.sv
// kamacore_dmem_lane_align: byte-lane enables, store replication and load extension
module kamacore_dmem_lane_align
  import kamacore_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH
) (
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rword,
  output logic [XLEN/8-1:0] o_byte_en,
  output logic [XLEN-1:0]   o_wword,
  output logic [XLEN-1:0]   o_rdata_ext,
  output logic              o_misaligned
);
  localparam int NB = XLEN / 8;
  logic            w_word, w_half;
  logic [1:0]      w_lane;
  logic [XLEN-1:0] w_shift;
  // reserved size 3 behaves as a word; the lane is forced to natural alignment
  always_comb begin
    w_word       = i_size[1];
    w_half       = i_size == MEM_HALF;
    w_lane       = w_word ? 2'b00 : w_half ? {i_addr[1], 1'b0} : i_addr;
    o_misaligned = w_word ? |i_addr : w_half & i_addr[0];
    o_byte_en    = w_word ? '1 : (w_half ? NB'(3) : NB'(1)) << w_lane;
    o_wword      = w_word ? i_wdata : w_half ? {(XLEN/16){i_wdata[15:0]}} : {(XLEN/8){i_wdata[7:0]}};
    w_shift      = i_rword >> {w_lane, 3'b000};
    o_rdata_ext  = w_word ? w_shift
                 : w_half ? {{(XLEN-16){~i_unsigned & w_shift[15]}}, w_shift[15:0]}
                 : {{(XLEN-8){~i_unsigned & w_shift[7]}}, w_shift[7:0]};
  end
endmodule

// File: rtl/kamacore_dmem_responder.sv
// kamacore_dmem_responder: valid/ready data-memory responder with wait states; KAMACORE_DMEM_MISALIGN_ERR_EN makes misaligned accesses error out
module kamacore_dmem_responder
  import kamacore_pkg::*;
#(
  parameter int XLEN        = CPU_WIDTH,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic              o_resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  dmem_state_e     r_state, w_next;
  logic [3:0]      r_cnt;
  logic            r_we, r_uns, r_err;
  logic [AW+1:0]   r_addr;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_wdata, r_rdata;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic            w_accept, w_enter, w_idle, w_we, w_uns, w_mis, w_err, w_unused;
  logic [AW+1:0]   w_addr;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_wdata, w_wword, w_rdata_ext;
  logic [NB-1:0]   w_be;

  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign w_accept     = i_req_valid && o_req_ready;
  assign w_enter      = w_next == DMEM_RESP && r_state != DMEM_RESP;
  assign w_idle       = r_state == DMEM_IDLE;
  assign w_we         = w_idle ? i_req_we : r_we;
  assign w_uns        = w_idle ? i_req_unsigned : r_uns;
  assign w_addr       = w_idle ? i_req_addr[AW+1:0] : r_addr;
  assign w_size       = w_idle ? i_req_size : r_size;
  assign w_wdata      = w_idle ? i_req_wdata : r_wdata;
  assign w_idx        = w_addr[AW+1:2];
  assign w_unused     = ^{i_req_addr, w_mis};
`ifdef KAMACORE_DMEM_MISALIGN_ERR_EN
  assign w_err = w_mis;
`else
  assign w_err = 1'b0;
`endif

  kamacore_dmem_lane_align #(.XLEN(XLEN)) u_align (
    .i_size      (w_size),
    .i_addr      (w_addr[1:0]),
    .i_unsigned  (w_uns),
    .i_wdata     (w_wdata),
    .i_rword     (r_mem[w_idx]),
    .o_byte_en   (w_be),
    .o_wword     (w_wword),
    .o_rdata_ext (w_rdata_ext),
    .o_misaligned(w_mis)
  );

  // next state and handshake outputs
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      DMEM_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = WAIT_STATES > 0 ? DMEM_WAIT : DMEM_RESP;
      end
      DMEM_WAIT: if (r_cnt == 4'd0) w_next = DMEM_RESP;
      DMEM_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = DMEM_IDLE;
      end
      default: w_next = DMEM_IDLE;
    endcase
  end

  // state, wait counter and the response registered on entry to RESP
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= DMEM_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_accept ? 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0) : r_cnt != 4'd0 ? r_cnt - 4'd1 : r_cnt;
      if (w_enter) begin
        r_rdata <= (w_we || w_err) ? '0 : w_rdata_ext;
        r_err   <= w_err;
      end
    end

  // request fields are captured only at accept
  always_ff @(posedge clk)
    if (w_accept) begin
      r_we    <= i_req_we;
      r_uns   <= i_req_unsigned;
      r_addr  <= i_req_addr[AW+1:0];
      r_size  <= i_req_size;
      r_wdata <= i_req_wdata;
    end

  // merge store lanes into the array when the store reaches RESP
  always_ff @(posedge clk)
    if (rst && w_enter && w_we && !w_err)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
endmodule
